// File: rtl/apb_regfile_slave.sv
// rtl/apb_regfile_slave.sv - APB completer with a register bank, write counter and programmable wait states

// Shared APB width constants used as parameter defaults.
package definesPkg;
  localparam int APB_ADDR_WIDTH = 32;
  localparam int APB_DATA_WIDTH = 32;
endpackage

module apb_regfile_slave #(
  parameter int APB_ADDR_WIDTH = definesPkg::APB_ADDR_WIDTH,
  parameter int APB_DATA_WIDTH = definesPkg::APB_DATA_WIDTH,
  parameter int NUM_REGS       = 8,
  parameter int WAIT_STATES    = 0
) (
  input  logic                      apbClk,
  input  logic                      rst,
  input  logic                      PSEL,
  input  logic                      PENABLE,
  input  logic                      PWRITE,
  input  logic [APB_ADDR_WIDTH-1:0] PADDR,
  input  logic [APB_DATA_WIDTH-1:0] PWDATA,
  output logic [APB_DATA_WIDTH-1:0] PRDATA,
  output logic                      PREADY,
  output logic                      PSLVERR
);

  // Byte-lane bits dropped from PADDR to form the word index.
  localparam int LANE_BITS = $clog2(APB_DATA_WIDTH / 8);
  localparam logic [APB_ADDR_WIDTH-1:0] WCNT_IDX  = APB_ADDR_WIDTH'(NUM_REGS - 1);
  localparam logic [APB_ADDR_WIDTH-1:0] NREG_IDX  = APB_ADDR_WIDTH'(NUM_REGS);
  localparam logic [3:0]                WAIT_LOAD = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_READY
  } state_t;

  state_t state, state_nxt;

  logic [APB_ADDR_WIDTH-1:0] setup_idx;
  logic [APB_ADDR_WIDTH-1:0] idx_q;
  logic [APB_ADDR_WIDTH-1:0] cur_idx;
  logic                      wr_q;
  logic                      cur_wr;
  logic                      cur_err;
  logic [3:0]                cnt_q, cnt_nxt;
  logic                      setup_seen;
  logic                      complete;
  logic                      do_write;
  logic                      enter_ready;
  logic                      pready_nxt;
  logic                      pslverr_nxt;
  logic [APB_DATA_WIDTH-1:0] prdata_nxt;
  logic [APB_DATA_WIDTH-1:0] rd_mux;
  logic [APB_DATA_WIDTH-1:0] wcnt_q;
  logic [APB_DATA_WIDTH-1:0] regs [NUM_REGS-1];

  assign setup_idx  = PADDR >> LANE_BITS;
  assign setup_seen = PSEL && !PENABLE;
  assign complete   = (state == ST_READY) && PSEL && PENABLE;
  // The error flag already registered on PSLVERR decides whether the write commits.
  assign do_write   = complete && wr_q && !PSLVERR;

  // In IDLE the decode must look at the live bus; later it uses the setup-phase latch.
  assign cur_idx     = (state == ST_IDLE) ? setup_idx : idx_q;
  assign cur_wr      = (state == ST_IDLE) ? PWRITE : wr_q;
  assign cur_err     = (cur_idx >= NREG_IDX) || (cur_wr && (cur_idx == WCNT_IDX));
  assign enter_ready = (state_nxt == ST_READY) && (state != ST_READY);

  // State register.
  always_ff @(posedge apbClk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; PSEL low in WAIT or READY aborts the transfer.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (setup_seen) begin
          state_nxt = (WAIT_STATES == 0) ? ST_READY : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!PSEL) begin
          state_nxt = ST_IDLE;
        end else if (cnt_q <= 4'd1) begin
          state_nxt = ST_READY;
        end
      end
      ST_READY: begin
        if (!PSEL || PENABLE) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Read data selection for the index being decoded; unmapped indices read as 0.
  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < NUM_REGS - 1; i++) begin
      if (cur_idx == APB_ADDR_WIDTH'(i)) begin
        rd_mux = regs[i];
      end
    end
    if (cur_idx == WCNT_IDX) begin
      rd_mux = wcnt_q;
    end
  end

  // Next values of the registered outputs and the wait counter.
  always_comb begin
    pready_nxt  = PREADY;
    pslverr_nxt = PSLVERR;
    prdata_nxt  = PRDATA;
    cnt_nxt     = cnt_q;
    if (enter_ready) begin
      pready_nxt  = 1'b1;
      pslverr_nxt = cur_err;
      if (!cur_wr) begin
        prdata_nxt = cur_err ? '0 : rd_mux;
      end
    end else if (state_nxt == ST_IDLE) begin
      pready_nxt  = 1'b0;
      pslverr_nxt = 1'b0;
    end
    if ((state == ST_IDLE) && setup_seen) begin
      cnt_nxt = WAIT_LOAD;
    end else if ((state == ST_WAIT) && (cnt_q != 4'd0)) begin
      cnt_nxt = cnt_q - 4'd1;
    end
  end

  // Setup-phase latch of word index and direction.
  always_ff @(posedge apbClk or negedge rst) begin
    if (!rst) begin
      idx_q <= '0;
      wr_q  <= 1'b0;
    end else if ((state == ST_IDLE) && setup_seen) begin
      idx_q <= setup_idx;
      wr_q  <= PWRITE;
    end
  end

  // Registered bus outputs and wait counter.
  always_ff @(posedge apbClk or negedge rst) begin
    if (!rst) begin
      PREADY  <= 1'b0;
      PSLVERR <= 1'b0;
      PRDATA  <= '0;
      cnt_q   <= 4'd0;
    end else begin
      PREADY  <= pready_nxt;
      PSLVERR <= pslverr_nxt;
      PRDATA  <= prdata_nxt;
      cnt_q   <= cnt_nxt;
    end
  end

  // Register bank and write counter; PWDATA is taken at the completion edge.
  always_ff @(posedge apbClk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS - 1; i++) begin
        regs[i] <= '0;
      end
      wcnt_q <= '0;
    end else if (do_write) begin
      for (int i = 0; i < NUM_REGS - 1; i++) begin
        if (idx_q == APB_ADDR_WIDTH'(i)) begin
          regs[i] <= PWDATA;
        end
      end
      wcnt_q <= wcnt_q + APB_DATA_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_apb_regfile_slave.sv
// tb/tb_apb_regfile_slave.sv - scoreboard bench for apb_regfile_slave at 0 and 3 wait states and 8-bit data
module tb_apb_regfile_slave;

  logic        apbClk;
  logic        rst;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic        psel0, psel3, psel8;
  logic [31:0] prdata0, prdata3;
  logic [7:0]  prdata8;
  logic        pready0, pready3, pready8;
  logic        pslverr0, pslverr3, pslverr8;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int          dut;
    bit          wr;
    bit          err;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];

  apb_regfile_slave #(.APB_ADDR_WIDTH(32), .APB_DATA_WIDTH(32), .NUM_REGS(8), .WAIT_STATES(0)) u_ws0 (
    .apbClk(apbClk), .rst(rst), .PSEL(psel0), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata0), .PREADY(pready0), .PSLVERR(pslverr0)
  );

  apb_regfile_slave #(.APB_ADDR_WIDTH(32), .APB_DATA_WIDTH(32), .NUM_REGS(8), .WAIT_STATES(3)) u_ws3 (
    .apbClk(apbClk), .rst(rst), .PSEL(psel3), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PRDATA(prdata3), .PREADY(pready3), .PSLVERR(pslverr3)
  );

  apb_regfile_slave #(.APB_ADDR_WIDTH(32), .APB_DATA_WIDTH(8), .NUM_REGS(8), .WAIT_STATES(0)) u_d8 (
    .apbClk(apbClk), .rst(rst), .PSEL(psel8), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata[7:0]), .PRDATA(prdata8), .PREADY(pready8), .PSLVERR(pslverr8)
  );

  initial apbClk = 1'b0;
  always #5 apbClk = ~apbClk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h required 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic rdy(input int d);
    return (d == 3) ? pready3 : ((d == 8) ? pready8 : pready0);
  endfunction

  task automatic set_sel(input int d, input logic v);
    if (d == 3) psel3 = v;
    else if (d == 8) psel8 = v;
    else psel0 = v;
  endtask

  // Monitor: pops one expectation per beat the DUT presents for completion.
  task automatic check_beat(input int d, input logic err, input logic [31:0] rd);
    exp_t e;
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL sb_underflow: got beat from dut %0d required no beat", d);
    end else begin
      e = sb.pop_front();
      chk("beat_dut", 32'(d), 32'(e.dut));
      chk("beat_pslverr", {31'b0, err}, {31'b0, e.err});
      if (!e.wr) chk("beat_prdata", rd, e.data);
    end
  endtask

  always @(negedge apbClk) begin
    if (penable && rst) begin
      if (psel0 && pready0) check_beat(0, pslverr0, prdata0);
      if (psel3 && pready3) check_beat(3, pslverr3, prdata3);
      if (psel8 && pready8) check_beat(8, pslverr8, {24'h0, prdata8});
    end
  end

  // One complete APB transfer; expected response goes to the scoreboard.
  task automatic xfer(input int d, input bit wr, input logic [31:0] addr, input logic [31:0] data,
                      input bit err, input logic [31:0] rexp);
    exp_t e;
    int   waits;
    bit   got;
    @(posedge apbClk); #1;
    set_sel(d, 1'b1);
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = data;
    e.dut = d; e.wr = wr; e.err = err; e.data = rexp;
    sb.push_back(e);
    @(posedge apbClk); #1;
    penable = 1'b1;
    waits = 0;
    got   = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge apbClk);
      if (rdy(d)) got = 1'b1;
      else waits++;
    end
    chk("pready_seen", {31'b0, got}, 32'd1);
    chk("wait_cycles", 32'(waits), (d == 3) ? 32'd3 : 32'd0);
    @(posedge apbClk); #1;
    set_sel(d, 1'b0);
    penable = 1'b0;
    @(negedge apbClk);
    chk("pready_pulse", {31'b0, rdy(d)}, 32'd0);
  endtask

  initial begin
    exp_t e;
    int   hi;
    rst = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    psel0 = 1'b0; psel3 = 1'b0; psel8 = 1'b0;
    repeat (3) @(posedge apbClk);
    @(negedge apbClk);
    chk("rst_pready", {29'b0, pready0, pready3, pready8}, 32'd0);
    chk("rst_pslverr", {29'b0, pslverr0, pslverr3, pslverr8}, 32'd0);
    chk("rst_prdata0", prdata0, 32'd0);
    chk("rst_prdata8", {24'h0, prdata8}, 32'd0);
    rst = 1'b1;

    // Zero wait states, 32-bit data.
    xfer(0, 0, 32'h0,  32'h0,        0, 32'h0);
    xfer(0, 1, 32'h4,  32'hDEADBEEF, 0, 32'h0);
    xfer(0, 0, 32'h4,  32'h0,        0, 32'hDEADBEEF);
    xfer(0, 0, 32'h6,  32'h0,        0, 32'hDEADBEEF);
    xfer(0, 0, 32'h1C, 32'h0,        0, 32'h1);
    xfer(0, 1, 32'h1C, 32'h55,       1, 32'h0);
    xfer(0, 0, 32'h1C, 32'h0,        0, 32'h1);
    xfer(0, 0, 32'h40, 32'h0,        1, 32'h0);
    xfer(0, 1, 32'h40, 32'h7,        1, 32'h0);
    xfer(0, 0, 32'h1C, 32'h0,        0, 32'h1);
    xfer(0, 0, 32'h8,  32'h0,        0, 32'h0);

    // Three wait states.
    xfer(3, 1, 32'h0,  32'h12345678, 0, 32'h0);
    xfer(3, 0, 32'h0,  32'h0,        0, 32'h12345678);
    xfer(3, 0, 32'h1C, 32'h0,        0, 32'h1);

    // Abort from WAIT: setup, enter access, then drop PSEL one cycle later.
    @(posedge apbClk); #1;
    psel3 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h8; pwdata = 32'hAAAA5555;
    @(posedge apbClk); #1;
    penable = 1'b1;
    @(posedge apbClk); #1;
    psel3 = 1'b0; penable = 1'b0;
    hi = 0;
    repeat (6) begin
      @(negedge apbClk);
      if (pready3) hi++;
    end
    chk("abort_pready", 32'(hi), 32'd0);
    xfer(3, 0, 32'h8,  32'h0, 0, 32'h0);
    xfer(3, 0, 32'h1C, 32'h0, 0, 32'h1);

    // Asynchronous reset while a write sits in READY.
    @(posedge apbClk); #1;
    psel0 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'hC; pwdata = 32'hCAFEF00D;
    e.dut = 0; e.wr = 1'b1; e.err = 1'b0; e.data = 32'h0;
    sb.push_back(e);
    @(posedge apbClk); #1;
    penable = 1'b1;
    @(negedge apbClk);
    chk("rst_mid_pready_before", {31'b0, pready0}, 32'd1);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_mid_pready", {31'b0, pready0}, 32'd0);
    chk("rst_mid_pslverr", {31'b0, pslverr0}, 32'd0);
    chk("rst_mid_prdata", prdata0, 32'd0);
    chk("rst_mid_prdata3", prdata3, 32'd0);
    psel0 = 1'b0; penable = 1'b0;
    @(negedge apbClk);
    rst = 1'b1;
    xfer(0, 0, 32'hC,  32'h0, 0, 32'h0);
    xfer(0, 0, 32'h4,  32'h0, 0, 32'h0);
    xfer(0, 0, 32'h1C, 32'h0, 0, 32'h0);

    // 8-bit data: WCNT at byte address 7 wraps after 256 writes.
    for (int i = 0; i < 256; i++) begin
      xfer(8, 1, 32'h0, 32'(i), 0, 32'h0);
    end
    xfer(8, 0, 32'h7, 32'h0, 0, 32'h0);
    xfer(8, 0, 32'h0, 32'h0, 0, 32'hFF);
    xfer(8, 1, 32'h7, 32'h3, 1, 32'h0);
    xfer(8, 0, 32'h8, 32'h0, 1, 32'h0);
    xfer(8, 1, 32'h3, 32'h5A, 0, 32'h0);
    xfer(8, 0, 32'h3, 32'h0, 0, 32'h5A);
    xfer(8, 0, 32'h7, 32'h0, 0, 32'h1);

    repeat (2) @(negedge apbClk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/apb_regfile_slave.md
# apb_regfile_slave

APB completer (slave) implementing a parameterised bank of 32-bit-style memory-mapped registers. It is the responder at the far end of the APB bus driven by the team's `apb_if` master tasks `writeData`, `readData`, `idleTicks` and `clearSignals`. It lets benches exercise those tasks against real RTL, with programmable wait states and error signalling. It sits on `apb_if` through the `slave` modport signal set, sharing the `definesPkg` width constants.

## Interface
- `APB_ADDR_WIDTH`, default `definesPkg::APB_ADDR_WIDTH`: PADDR width.
- `APB_DATA_WIDTH`, default `definesPkg::APB_DATA_WIDTH`: PWDATA/PRDATA width; a multiple of 8.
- `NUM_REGS`, default 8: register count, at least 2. Index `NUM_REGS-1` is a read-only write counter; the rest are R/W.
- `WAIT_STATES`, default 0: wait cycles inserted before PREADY (0..15). Default 0 suits masters that ignore PREADY.
- `apbClk`, in, 1: clock; all state updates on its rising edge.
- `rst`, in, 1: reset; one clock; reset is asynchronous and active-low.
- `PSEL`, in, 1: slave select.
- `PENABLE`, in, 1: access phase.
- `PWRITE`, in, 1: 1 = write, 0 = read.
- `PADDR`, in, APB_ADDR_WIDTH: byte address.
- `PWDATA`, in, APB_DATA_WIDTH: write data.
- `PRDATA`, out, APB_DATA_WIDTH: read data, registered.
- `PREADY`, out, 1: transfer completes on the edge where PSEL, PENABLE and PREADY are all 1. Registered.
- `PSLVERR`, out, 1: error, valid only while PREADY=1. Registered.

## Operation
- Word index = `PADDR >> log2(APB_DATA_WIDTH/8)`; the low byte-lane bits are ignored.
  - Index < NUM_REGS-1: R/W storage.
  - Index == NUM_REGS-1: WCNT, a read-only count of successful writes, APB_DATA_WIDTH wide, wraps to 0.
  - Index >= NUM_REGS: invalid.
- FSM states IDLE, WAIT, READY. A 4-bit wait counter, plus latched index and latched write flag.
- IDLE:
  - Sampling PSEL=1 and PENABLE=0 (setup phase) latches PADDR index and PWRITE, and loads the counter with WAIT_STATES.
  - If WAIT_STATES==0, go to READY. Otherwise go to WAIT.
  - PSEL=1 with PENABLE=1 while in IDLE (protocol violation) is ignored.
- WAIT:
  - Counter decrements each edge; PREADY=0.
  - When the counter reaches 1, go to READY.
- Entering READY:
  - PREADY<=1.
  - PSLVERR<=1 if the index is invalid, or if a write targets WCNT.
  - On a valid read, PRDATA is loaded with the register, or WCNT.
  - On an error read, PRDATA is loaded with 0.
- READY, on sampling PSEL & PENABLE:
  - Completion. A valid write stores PWDATA at that edge and increments WCNT.
  - An error write is discarded; WCNT is unchanged.
  - Go to IDLE with PREADY<=0 and PSLVERR<=0.
- Abort: PSEL=0 sampled in WAIT or READY returns to IDLE. No write, no WCNT change, PREADY and PSLVERR cleared.
- Address and write flag come from the setup-phase latch; PWDATA is sampled at completion.
- PRDATA holds its last loaded value until the next read enters READY. Writes never alter PRDATA.

## Timing
- Reset (asynchronous, rst=0):
  - State IDLE.
  - PREADY=0, PSLVERR=0, PRDATA=0.
  - All registers 0, WCNT=0.
  - Reset mid-transfer abandons the transfer with no write.
- WAIT_STATES=0:
  - Setup edge T: PREADY=1 and PRDATA valid after T.
  - Completes at T+1; this is the standard 2-cycle APB transfer.
  - Write data is visible to a read whose setup phase is sampled at T+2 or later.
- WAIT_STATES=N>0: PREADY rises after edge T+N; completion at T+N+1.
- Back-to-back: a setup phase sampled the edge after completion is accepted with no idle cycle.
- PREADY is a single-cycle pulse per completed transfer, unless the master stretches PENABLE. The master cannot stretch PENABLE past completion because the state returns to IDLE.

## Test plan
- Reset, then `readData(0x0)` -> PRDATA=0, PSLVERR=0. Every output is 0 during rst=0.
- WAIT_STATES=0: `writeData(0x4, 0xDEADBEEF)` then `readData(0x4)` -> data 0xDEADBEEF. Reading WCNT at index NUM_REGS-1 (addr 0x1C for 32-bit data) -> 1. PREADY high exactly one cycle per transfer.
- `writeData(0x1C, 0x55)` -> PSLVERR=1 with PREADY; WCNT stays 1. `readData(0x40)` -> PSLVERR=1, PRDATA=0.
- WAIT_STATES=3, raw pin drive: setup at edge T -> PREADY rises after T+3. A write of 0x12345678 commits at T+4; a readback returns it.
- Abort: PSEL dropped while in WAIT (WAIT_STATES=3) -> state IDLE, no write, WCNT unchanged.
- Async reset mid-READY of a write -> outputs 0 immediately, target register stays 0. 256 writes wrap an 8-bit-data WCNT to 0.
